// File: rtl/alu_sequencer.sv
// Round-robin arbiter and sequencer for a shared 4-bit ALU: accepts one request,
// holds operands for a settle window, captures the ALU outputs and returns a tagged response.
module alu_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [1:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [1:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_gt,
    output logic       rsp_eq,
    output logic       rsp_lt,
    output logic       busy,
    output logic       alu_s0,
    output logic       alu_s1,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_sum,
    input  logic       alu_carry,
    input  logic       alu_gt,
    input  logic       alu_eq,
    input  logic       alu_lt,
    input  logic [3:0] alu_and
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               prio;      // 0: req0 holds priority, 1: req1 holds priority
    logic [CNT_W-1:0]   cnt;
    logic               id_q;
    logic               grant0;
    logic               grant1;
    logic               accept;
    logic [1:0]         win_op;
    logic [3:0]         win_a;
    logic [3:0]         win_b;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and grant decode; grants are gated by reset so no handshake completes under it
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                grant0 = rst_n && req0_valid && (!prio || !req1_valid);
                grant1 = rst_n && req1_valid && (prio || !req0_valid);
                if (grant0 || grant1) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 || grant1;
    assign win_op     = grant1 ? req1_op : req0_op;
    assign win_a      = grant1 ? req1_a  : req0_a;
    assign win_b      = grant1 ? req1_b  : req0_b;

    // Operand launch, settle count and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio       <= 1'b0;
            cnt        <= '0;
            id_q       <= 1'b0;
            busy       <= 1'b0;
            alu_s0     <= 1'b0;
            alu_s1     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_gt     <= 1'b0;
            rsp_eq     <= 1'b0;
            rsp_lt     <= 1'b0;
        end else begin
            busy      <= (state_next != IDLE);
            rsp_valid <= (state_next == RESP);
            if (accept) begin
                prio   <= grant0;
                id_q   <= grant1;
                alu_s1 <= win_op[1];
                alu_s0 <= win_op[0];
                alu_a  <= win_a;
                alu_b  <= win_b;
                cnt    <= CNT_W'(SETTLE_CYCLES);
            end
            if (state == SETTLE) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    rsp_id     <= id_q;
                    rsp_result <= (alu_s1 && alu_s0) ? alu_and : alu_sum;
                    rsp_carry  <= alu_carry;
                    rsp_gt     <= alu_gt;
                    rsp_eq     <= alu_eq;
                    rsp_lt     <= alu_lt;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vectors, multi-cycle corner cases,
// contention spacing at two settle lengths, and randomized traffic against a transaction model.
module tb_alu_sequencer;

    localparam int S1 = 1;
    localparam int S4 = 4;

    typedef struct packed {
        logic [3:0] sum;
        logic       carry;
        logic       gt;
        logic       eq;
        logic       lt;
        logic [3:0] andv;
    } alu_out_t;

    typedef struct packed {
        logic       id;
        logic [3:0] result;
        logic       carry;
        logic       gt;
        logic       eq;
        logic       lt;
    } rsp_t;

    typedef struct {
        logic       id;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        rsp_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req1_valid, rsp_ready;
    logic [1:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;

    logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry, rsp_gt, rsp_eq, rsp_lt, busy;
    logic alu_s0, alu_s1;
    logic [3:0] rsp_result, alu_a, alu_b;

    logic r0_4, r1_4, rv_4, rid_4, rc_4, rgt_4, req_4, rlt_4, busy_4, s0_4, s1_4;
    logic [3:0] rres_4, a_4, b_4;

    alu_out_t m1, m4;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 4-bit ALU: 00 add, otherwise subtract (carry = borrow); compare and AND always live
    function automatic alu_out_t alu_model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] t;
        alu_out_t o;
        if (op == 2'b00) t = {1'b0, a} + {1'b0, b};
        else             t = {1'b0, a} - {1'b0, b};
        o.sum   = t[3:0];
        o.carry = t[4];
        o.gt    = (a > b);
        o.eq    = (a == b);
        o.lt    = (a < b);
        o.andv  = a & b;
        return o;
    endfunction

    // Expected response computed with plain integer arithmetic
    function automatic rsp_t rsp_model(input logic id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia;
        int ib;
        int r;
        rsp_t e;
        ia = int'(a);
        ib = int'(b);
        r  = (op == 2'b00) ? ia + ib : ia - ib;
        e.id     = id;
        e.result = (op == 2'b11) ? (a & b) : 4'(r & 15);
        e.carry  = (op == 2'b00) ? (r > 15) : (r < 0);
        e.gt     = (ia > ib);
        e.eq     = (ia == ib);
        e.lt     = (ia < ib);
        return e;
    endfunction

    assign m1 = alu_model({alu_s1, alu_s0}, alu_a, alu_b);
    assign m4 = alu_model({s1_4, s0_4}, a_4, b_4);

    alu_sequencer #(.SETTLE_CYCLES(S1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt), .busy(busy),
        .alu_s0(alu_s0), .alu_s1(alu_s1), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sum(m1.sum), .alu_carry(m1.carry), .alu_gt(m1.gt), .alu_eq(m1.eq), .alu_lt(m1.lt), .alu_and(m1.andv)
    );

    alu_sequencer #(.SETTLE_CYCLES(S4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(r0_4), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(r1_4), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rv_4), .rsp_ready(rsp_ready), .rsp_id(rid_4), .rsp_result(rres_4),
        .rsp_carry(rc_4), .rsp_gt(rgt_4), .rsp_eq(req_4), .rsp_lt(rlt_4), .busy(busy_4),
        .alu_s0(s0_4), .alu_s1(s1_4), .alu_a(a_4), .alu_b(b_4),
        .alu_sum(m4.sum), .alu_carry(m4.carry), .alu_gt(m4.gt), .alu_eq(m4.eq), .alu_lt(m4.lt), .alu_and(m4.andv)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rsp(input string tag, input rsp_t e);
        chk({tag, "_id"},     rsp_id,     e.id);
        chk({tag, "_result"}, rsp_result, e.result);
        chk({tag, "_carry"},  rsp_carry,  e.carry);
        chk({tag, "_gt"},     rsp_gt,     e.gt);
        chk({tag, "_eq"},     rsp_eq,     e.eq);
        chk({tag, "_lt"},     rsp_lt,     e.lt);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready0"}, req0_ready, 0);
        chk({tag, "_ready1"}, req1_ready, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_alu"},    {alu_s1, alu_s0, alu_a, alu_b}, 0);
        chk({tag, "_rsp"},    {rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_gt, rsp_eq, rsp_lt}, 0);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_op = 2'b00; req0_a = 4'h0; req0_b = 4'h0;
        req1_op = 2'b00; req1_a = 4'h0; req1_b = 4'h0;
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for rsp_valid on dut; returns cycles waited
    task automatic wait_rsp(output int waited);
        waited = 0;
        while (!rsp_valid && waited < 30) begin
            step();
            smp();
            waited++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        step();
        rsp_ready = 1'b1;
        if (v.id) begin
            req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
        end else begin
            req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
        end
        smp();
        chk("vec_ready0", req0_ready, !v.id);
        chk("vec_ready1", req1_ready, v.id);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        smp();
        chk("vec_alu_sel", {alu_s1, alu_s0}, v.op);
        chk("vec_alu_a", alu_a, v.a);
        chk("vec_alu_b", alu_b, v.b);
        chk("vec_busy", busy, 1);
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            step();
            smp();
            lat++;
        end
        chk("vec_latency", lat, 1 + S1);
        chk_rsp("vec", v.exp);
        step();
        smp();
        chk("vec_after_valid", rsp_valid, 0);
        chk("vec_after_busy", busy, 0);
    endtask

    vec_t vecs[6];
    int   ids1[$], cy1[$], ids4[$], cy4[$];
    rsp_t exp_q[$];

    initial begin
        int   w;
        logic [3:0] held;
        bit   outstanding, last_grant, pend0, pend1, hs0, hs1, e0, e1, ev;
        int   acc_cyc, nrsp;
        rsp_t r;

        vecs[0] = '{id: 1'b0, op: 2'b11, a: 4'b0101, b: 4'b1001, exp: '{1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[1] = '{id: 1'b1, op: 2'b00, a: 4'b1001, b: 4'b0111, exp: '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{id: 1'b0, op: 2'b10, a: 4'b0101, b: 4'b0101, exp: '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{id: 1'b0, op: 2'b10, a: 4'b0011, b: 4'b0110, exp: '{1'b0, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b1}};
        vecs[4] = '{id: 1'b1, op: 2'b01, a: 4'b0111, b: 4'b0010, exp: '{1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[5] = '{id: 1'b1, op: 2'b11, a: 4'b1111, b: 4'b1010, exp: '{1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0}};

        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        smp();
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Backpressure: response held while rsp_ready low, no new grant meanwhile
        step();
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'd3; req0_b = 4'd4; rsp_ready = 1'b0;
        smp();
        chk("bp_accept", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 4'hC; req1_b = 4'hA;
        smp();
        wait_rsp(w);
        chk("bp_rsp_seen", rsp_valid, 1);
        held = rsp_result;
        for (int i = 0; i < 5; i++) begin
            step();
            smp();
            chk("bp_valid", rsp_valid, 1);
            chk("bp_result", rsp_result, 7);
            chk("bp_stable", rsp_result, held);
            chk("bp_id", rsp_id, 0);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            chk("bp_busy", busy, 1);
        end
        step();
        rsp_ready = 1'b1;
        smp();
        chk("bp_release_ready1", req1_ready, 0);
        step();
        smp();
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_ready1", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        smp();
        wait_rsp(w);
        chk("bp_second_id", rsp_id, 1);
        chk("bp_second_result", rsp_result, 8);
        step();

        // Reset during SETTLE after a req0 grant (priority had moved to req1)
        step();
        req0_valid = 1'b1; req0_op = 2'b11; req0_a = 4'h6; req0_b = 4'h5; rsp_ready = 1'b1;
        smp();
        chk("rs_accept", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        smp();
        chk("rs_in_settle", busy, 1);
        step();
        rst_n = 1'b1;
        smp();
        chk_all_zero("rs_after");
        for (int i = 0; i < 6; i++) begin
            step();
            smp();
            chk("rs_no_rsp", rsp_valid, 0);
        end
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 2'b00; req0_a = 4'h1; req0_b = 4'h2;
        req1_op = 2'b00; req1_a = 4'h3; req1_b = 4'h4;
        smp();
        chk("rs_prio_ready0", req0_ready, 1);
        chk("rs_prio_ready1", req1_ready, 0);

        // Contention on both settle lengths
        do_reset();
        req0_valid = 1'b1; req0_op = 2'b00; req0_a = 4'h1; req0_b = 4'h2;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 4'hF; req1_b = 4'h3;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            smp();
            if (req0_ready) begin ids1.push_back(0); cy1.push_back(cyc); end
            if (req1_ready) begin ids1.push_back(1); cy1.push_back(cyc); end
            if (r0_4) begin ids4.push_back(0); cy4.push_back(cyc); end
            if (r1_4) begin ids4.push_back(1); cy4.push_back(cyc); end
            step();
        end
        chk("cont1_count", ids1.size() >= 4, 1);
        chk("cont4_count", ids4.size() >= 4, 1);
        for (int i = 0; i < 4 && i < ids1.size(); i++) chk("cont1_order", ids1[i], i % 2);
        for (int i = 0; i < 4 && i < ids4.size(); i++) chk("cont4_order", ids4[i], i % 2);
        for (int i = 1; i < 4 && i < cy1.size(); i++) chk("cont1_gap", cy1[i] - cy1[i-1], 2 + S1);
        for (int i = 1; i < 4 && i < cy4.size(); i++) chk("cont4_gap", cy4[i] - cy4[i-1], 2 + S4);

        // Randomized traffic against the transaction-level model
        do_reset();
        outstanding = 0; last_grant = 1; pend0 = 0; pend1 = 0; hs0 = 0; hs1 = 0;
        acc_cyc = 0; nrsp = 0;
        for (int c = 0; c < 500; c++) begin
            if (c > 0) step();
            if (hs0) pend0 = 0;
            if (hs1) pend1 = 0;
            if (!pend0 && $urandom_range(0, 2) == 0) begin
                pend0 = 1; req0_op = 2'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
            end
            if (!pend1 && $urandom_range(0, 2) == 0) begin
                pend1 = 1; req1_op = 2'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
            end
            req0_valid = pend0;
            req1_valid = pend1;
            rsp_ready  = 1'($urandom);
            smp();
            e0 = !outstanding && pend0 && (!pend1 || last_grant);
            e1 = !outstanding && pend1 && (!pend0 || !last_grant);
            ev = outstanding && (cyc - acc_cyc >= 1 + S1);
            chk("rnd_ready0", req0_ready, e0);
            chk("rnd_ready1", req1_ready, e1);
            chk("rnd_busy", busy, outstanding);
            chk("rnd_rsp_valid", rsp_valid, ev);
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk_rsp("rnd", r);
                outstanding = 0;
                nrsp++;
            end
            if (hs0 || hs1) begin
                outstanding = 1;
                acc_cyc     = cyc;
                last_grant  = hs1;
                if (hs1) exp_q.push_back(rsp_model(1'b1, req1_op, req1_a, req1_b));
                else     exp_q.push_back(rsp_model(1'b0, req0_op, req0_a, req0_b));
            end
        end
        chk("rnd_progress", nrsp > 20, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Two-requester arbiter and sequencer for the shared 4-bit ALU (add/sub, compare, AND unit).
- Accepts operation requests from two clients over valid/ready handshakes and grants the ALU round-robin.
- Drives the ALU select lines and operands from registers, holds them stable for a settle window, then captures the ALU outputs.
- Returns a tagged result on a single valid/ready response channel.

## Interface
Parameters:
- SETTLE_CYCLES, 1, cycles operands are held on the ALU before capture; legal range 1..15.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_op / req1_op  in  2  operation, driven to ALU as {s1,s0}
- req0_a, req0_b / req1_a, req1_b  in  4  operands
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  1  requester that issued the response
- rsp_result  out  4  sum/difference (op 00, 01, 10) or AND bits (op 11)
- rsp_carry  out  1  ALU carry/borrow
- rsp_gt, rsp_eq, rsp_lt  out  1  comparator flags
- busy  out  1  high in any state except IDLE
- alu_s0, alu_s1  out  1  ALU select, registered
- alu_a, alu_b  out  4  ALU operands, registered
- alu_sum  in  4  ALU add/sub output bits s3..s0
- alu_carry  in  1  ALU carry
- alu_gt, alu_eq, alu_lt  in  1  ALU comparator outputs
- alu_and  in  4  ALU AND output bits

## Operation
States:
- IDLE: arbitrate and accept one request.
- SETTLE: hold operands for SETTLE_CYCLES cycles, then capture.
- RESP: present the response and wait for rsp_ready.

Arbitration:
- Round-robin priority pointer; after reset req0 has priority.
- Only one of req0_ready / req1_ready is ever high.
- readyN is high only in IDLE when requester N wins: valid and (holds priority, or the other requester is not valid).
- On an accepted handshake (valid && ready), priority moves to the other requester.

Accept:
- Latch op, a and b into alu_s1/alu_s0/alu_a/alu_b; latch the winner's index for rsp_id.
- Load the settle counter with SETTLE_CYCLES; go to SETTLE.

SETTLE:
- Decrement the counter each cycle.
- On the cycle it reads 1, capture the ALU outputs:
  - rsp_result = alu_and if op == 11, else alu_sum
  - rsp_carry, rsp_gt, rsp_eq, rsp_lt captured from the corresponding ALU inputs
- Go to RESP.

RESP:
- rsp_valid high; all rsp_* fields stable until rsp_valid && rsp_ready, then go to IDLE.

General rules:
- ALU select/operand outputs hold their last values in IDLE and RESP; they change only on accept.
- Requesters must hold valid and payload stable until ready. A valid dropped before ready is simply not granted.

## Timing
- Reset (rst_n low at a rising edge):
  - State returns to IDLE and priority returns to req0.
  - All outputs are 0: ready, rsp_*, busy, alu_s0/s1, alu_a/b.
- Reset mid-operation (SETTLE or RESP) discards the transaction; no response is produced.
- Handshake sampled in cycle 0:
  - alu_* show the new op/operands from cycle 1.
  - busy is high from cycle 1.
  - rsp_valid rises in cycle 1+SETTLE_CYCLES.
- If rsp_ready is high in that same cycle, IDLE is reached in cycle 2+SETTLE_CYCLES, so a new ready can occur then.
- Minimum spacing between accepts is 2+SETTLE_CYCLES cycles.
- Backpressure: rsp_ready low holds RESP indefinitely; no request is accepted while in RESP.
- Both requesters valid in the same IDLE cycle: the priority holder is granted; the other waits at least 2+SETTLE_CYCLES cycles.
- Continuous contention alternates grants 0,1,0,1…
- A requester valid alone is granted regardless of priority.
- Settle counter width is 4 bits; no wrap occurs within the legal parameter range.

## Test plan
- AND: after reset, req0 op=11, a=0101, b=1001, rsp_ready=1 → rsp_valid in cycle 2 (SETTLE_CYCLES=1) with rsp_id=0, rsp_result=0001; alu_s1=alu_s0=1 from cycle 1.
- Add overflow (ALU model 00=add): req1 op=00, a=1001, b=0111 → rsp_id=1, rsp_result=0000, rsp_carry=1.
- Compare: req0 op=10, a=0101, b=0101 → rsp_eq=1, rsp_gt=0, rsp_lt=0; with a=0011, b=0110 → rsp_lt=1.
- Contention: both valid from cycle 0, held after each accept → grants in order id 0,1,0,1; accepts spaced exactly 3 cycles apart with SETTLE_CYCLES=1, and 6 apart with SETTLE_CYCLES=4.
- Backpressure: rsp_ready held low 5 cycles → rsp_* constant, req*_ready stay 0, busy=1; raising rsp_ready gives IDLE the next cycle.
- Reset mid-SETTLE: rst_n low one cycle during SETTLE → next cycle all outputs 0, no rsp_valid ever for that request, next grant goes to req0.
